// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial add/subtract engine: FSM states and carry-in encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Subtract is a + ~b + 1, so the carry register is seeded with the op bit.
  localparam logic CinAdd = 1'b0;
  localparam logic CinSub = 1'b1;

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell, the only arithmetic in the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder cell is reused for WIDTH cycles, LSB first,
// between a valid/ready operand handshake and a valid/ready result handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ovf_q, in_ready_q, out_valid_q;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] psum_next;

  fulladder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign psum_next = {fa_sum, psum_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      psum_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= op_sub ? ~b : b;
            carry_q    <= op_sub ? CinSub : CinAdd;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          psum_q  <= psum_next;
          carry_q <= fa_cout;
          if (cnt_q == CntLast) begin
            // carry_q is the carry into the MSB during the final bit
            sum_q       <= psum_next;
            cout_q      <= fa_cout;
            ovf_q       <= carry_q ^ fa_cout;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: directed vector table and corner sequences on a 16-bit instance,
// plus randomized traffic on 16-, 2- and 32-bit instances against an arithmetic model.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 16-bit instance
  logic        rst16 = 1'b1;
  logic        in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  // 2-bit and 32-bit instances share one startup reset
  logic        rst_r = 1'b1;
  logic        iv2 = 1'b0, sb2 = 1'b0, or2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0, sm2;
  logic        ir2, ov2, co2, vf2;
  logic        iv32 = 1'b0, sb32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, sm32;
  logic        ir32, ov32, co32, vf32;

  bit done2 = 1'b0, done32 = 1'b0;

  serial_adder_ctrl #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst16), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst_r), .in_valid(iv2), .in_ready(ir2), .op_sub(sb2),
    .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .sum(sm2), .cout(co2), .ovf(vf2)
  );

  serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst_r), .in_valid(iv32), .in_ready(ir32), .op_sub(sb32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .sum(sm32), .cout(co32),
    .ovf(vf32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} of (a +/- b) mod 2^w from plain integer arithmetic.
  function automatic logic [65:0] model(input int unsigned w, input logic [63:0] x,
                                        input logic [63:0] y, input logic sub);
    logic [63:0] mask, xm, ym, s;
    logic [64:0] full;
    logic        sx, sy, sr, c, v;
    mask = (64'd1 << w) - 64'd1;
    xm   = x & mask;
    ym   = sub ? (~y & mask) : (y & mask);
    full = {1'b0, xm} + {1'b0, ym} + {64'd0, sub};
    s    = full[63:0] & mask;
    c    = full[w];
    sx   = x[w-1];
    sy   = y[w-1];
    sr   = s[w-1];
    v    = sub ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
    return {v, c, s};
  endfunction

  task automatic wait_result(input string nm, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd17);
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_drain"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  task automatic do_op(input string nm, input logic sub, input logic [15:0] ta,
                       input logic [15:0] tb_, input logic [15:0] es, input logic ec,
                       input logic eo);
    int lat;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    op_sub   = sub;
    a        = ta;
    b        = tb_;
    @(negedge clk);
    // operands change after the accept edge and must be ignored
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    op_sub   = ~sub;
    wait_result(nm, lat);
    chk({nm, "_res"}, 64'({sum, cout, ovf}), 64'({es, ec, eo}));
    drain(nm);
  endtask

  typedef struct {
    string       nm;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  initial begin : main
    vec_t        vt[8];
    int          lat;
    bit          seen;
    logic [65:0] q16[$];
    logic [65:0] e;
    int          got;

    vt[0] = '{"add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{"add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{"add_1234",   1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vt[3] = '{"sub_5_7",    1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{"sub_8000_1", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{"sub_5_5",    1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{"add_8000x2", 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vt[7] = '{"add_0_0",    1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({in_ready, out_valid, sum, cout, ovf}), 64'({2'b10, 18'd0}));
    rst16 = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'({in_ready, out_valid}), 64'(2'b10));

    foreach (vt[i]) do_op(vt[i].nm, vt[i].sub, vt[i].a, vt[i].b, vt[i].s, vt[i].c, vt[i].v);

    // Back-pressure with a competing operand held on the input
    in_valid = 1'b1; op_sub = 1'b1; a = 16'h8000; b = 16'h0001;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111; op_sub = 1'b0;
    wait_result("bp", lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 64'({out_valid, in_ready, sum, cout, ovf}),
          64'({2'b10, 16'h7FFF, 2'b11}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_idle", 64'({out_valid, in_ready}), 64'(2'b01));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accept", 64'(in_ready), 64'd0);
    wait_result("bp2", lat);
    chk("bp2_res", 64'({sum, cout, ovf}), 64'({16'hBBBB, 2'b00}));
    drain("bp2");

    // Reset during the 5th RUN cycle
    in_valid = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h4321;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    chk("rst_run", 64'({in_ready, out_valid, sum, cout, ovf}), 64'({2'b10, 18'd0}));
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= out_valid;
    end
    out_ready = 1'b0;
    chk("rst_no_valid", 64'(seen), 64'd0);

    // Randomized traffic on the 16-bit instance
    got = 0;
    for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      op_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) q16.push_back(model(16, 64'(a), 64'(b), op_sub));
      if (out_valid && out_ready) begin
        if (q16.size() == 0) chk("r16_spurious", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          chk("r16_res", 64'({sum, cout, ovf}), 64'({e[15:0], e[64], e[65]}));
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("r16_count", 64'(got), 64'd1000);

    for (int i = 0; i < 60000 && !(done2 && done32); i++) @(negedge clk);
    chk("rand_done", 64'({done2, done32}), 64'(2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : rand2
    logic [65:0] q[$];
    logic [65:0] e;
    int          got;
    got = 0;
    repeat (3) @(negedge clk);
    rst_r = 1'b0;
    for (int cyc = 0; cyc < 30000 && got < 400; cyc++) begin
      @(negedge clk);
      iv2 = ($urandom_range(0, 3) != 0);
      a2  = 2'($urandom);
      b2  = 2'($urandom);
      sb2 = 1'($urandom_range(0, 1));
      or2 = ($urandom_range(0, 2) != 0);
      if (iv2 && ir2) q.push_back(model(2, 64'(a2), 64'(b2), sb2));
      if (ov2 && or2) begin
        if (q.size() == 0) chk("r2_spurious", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("r2_res", 64'({sm2, co2, vf2}), 64'({e[1:0], e[64], e[65]}));
        end
        got++;
      end
    end
    iv2 = 1'b0;
    chk("r2_count", 64'(got), 64'd400);
    done2 = 1'b1;
  end

  initial begin : rand32
    logic [65:0] q[$];
    logic [65:0] e;
    int          got;
    got = 0;
    repeat (4) @(negedge clk);
    for (int cyc = 0; cyc < 40000 && got < 400; cyc++) begin
      @(negedge clk);
      iv32 = ($urandom_range(0, 3) != 0);
      a32  = $urandom;
      b32  = $urandom;
      sb32 = 1'($urandom_range(0, 1));
      or32 = ($urandom_range(0, 2) != 0);
      if (iv32 && ir32) q.push_back(model(32, 64'(a32), 64'(b32), sb32));
      if (ov32 && or32) begin
        if (q.size() == 0) chk("r32_spurious", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("r32_res", 64'({sm32, co32, vf32}), 64'({e[31:0], e[64], e[65]}));
        end
        got++;
      end
    end
    iv32 = 1'b0;
    chk("r32_count", 64'(got), 64'd400);
    done32 = 1'b1;
  end

endmodule
